// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready load/store port.
// One access in flight at a time; optional fixed wait states before the response.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, nextState;
  logic [3:0]  waitCnt, nextCnt;
  logic        accept, commit;

  logic        capWe_p0;
  logic [2:0]  capFunct3_p0;
  logic [31:0] capAddr_p0;
  logic [31:0] capWdata_p0;

  logic        opWe;
  logic [2:0]  opFunct3;
  logic [31:0] opAddr;
  logic [31:0] opWdata;
  logic        opErr;
  logic [AW-1:0] opIdx;
  logic [31:0] curWord;

  logic [31:0] mem [DEPTH];

  function automatic logic accessErr(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr[0];
      3'b010:  bad = addr[1] | addr[0];
      3'b100:  bad = we;
      3'b101:  bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    return bad | (addr >= ADDR_LIMIT);
  endfunction

  function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    logic [31:0]        r;
    case (lane)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    ext = '0;
    r   = '0;
    case (f3)
      3'b000: begin ext = b; r = ext; end
      3'b001: begin ext = h; r = ext; end
      3'b010: r = word;
      3'b100: r = {24'd0, b};
      3'b101: r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] storeMerge(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] lane, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000:
        case (lane)
          2'd0: r[7:0]   = wdata[7:0];
          2'd1: r[15:8]  = wdata[7:0];
          2'd2: r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      3'b001:
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      3'b010: r = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

  // req_ready is forced low for the whole time rst is held, not just until the next edge
  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);

  always_comb begin
    nextState = state;
    nextCnt   = waitCnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE:
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            nextState = WAIT;
            nextCnt   = WAIT_LOAD;
          end else begin
            nextState = RESP;
            commit    = 1'b1;
          end
        end
      WAIT:
        if (waitCnt == 4'd0) begin
          nextState = RESP;
          commit    = 1'b1;
        end else begin
          nextCnt = waitCnt - 4'd1;
        end
      RESP:
        if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= nextState;
      waitCnt <= nextCnt;
    end
  end

  // Stage p0: request capture; with no wait states the commit uses the live request
  always_ff @(posedge clk) begin
    if (accept) begin
      capWe_p0     <= req_we;
      capFunct3_p0 <= req_funct3;
      capAddr_p0   <= req_addr;
      capWdata_p0  <= req_wdata;
    end
  end

  always_comb begin
    opWe     = (state == IDLE) ? req_we     : capWe_p0;
    opFunct3 = (state == IDLE) ? req_funct3 : capFunct3_p0;
    opAddr   = (state == IDLE) ? req_addr   : capAddr_p0;
    opWdata  = (state == IDLE) ? req_wdata  : capWdata_p0;
    opErr    = accessErr(opWe, opFunct3, opAddr);
    opIdx    = opAddr[AW+1:2];
    curWord  = mem[opIdx];
  end

  // Stage p1: commit edge -- array write and response capture happen together
  always_ff @(posedge clk) begin
    if (commit && opWe && !opErr)
      mem[opIdx] <= storeMerge(curWord, opFunct3, opAddr[1:0], opWdata);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= (opWe || opErr) ? 32'd0 : loadExtend(curWord, opFunct3, opAddr[1:0]);
      rsp_err   <= opErr;
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, 1024, number of 32-bit words in the data array; SHALL be a power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, 0, extra wait states per access; SHALL be 0..15.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  core presents a load/store request.
REQ-006 Port req_ready  output  1  block can accept a request.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 Port req_addr  input  32  byte address.
REQ-010 Port req_wdata  input  32  store data, right-aligned.
REQ-011 Port rsp_valid  output  1  response available.
REQ-012 Port rsp_ready  input  1  core accepts the response.
REQ-013 Port rsp_rdata  output  32  load result, extended per funct3.
REQ-014 Port rsp_err  output  1  request was misaligned, out of range or had an illegal funct3.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready; on accept, capture req_we, req_funct3, req_addr and req_wdata, then go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-017 WAIT: load a down-counter with WAIT_CYCLES-1 on accept; go to RESP on the edge where the counter equals 0.
REQ-018 rsp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-019 Commit edge = the edge entering RESP; the store write and the load-data capture SHALL both occur only on that edge.
REQ-020 Word index = addr[log2(DEPTH)+1:2]; addr >= 4*DEPTH SHALL set rsp_err.
REQ-021 Misaligned requests SHALL set rsp_err: H/HU with addr[0]=1; W with addr[1:0]!=0. funct3 of 011, 110 or 111 SHALL also set rsp_err; for stores, any funct3 other than 000/001/010 is illegal.
REQ-022 On an erroneous access: no array write, rsp_rdata=0.
REQ-023 SB SHALL write wdata[7:0] to byte lane addr[1:0] only; SH SHALL write wdata[15:0] to lanes {addr[1],0} and {addr[1],1}; SW SHALL write all four lanes; other lanes SHALL be unchanged.
REQ-024 Loads SHALL select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W returns the word.
REQ-025 Store responses SHALL return rsp_rdata=0 and rsp_err per REQ-020/021.
REQ-026 RESP: rsp_valid=1, and rsp_rdata and rsp_err SHALL stay stable until rsp_valid & rsp_ready; on that edge go to IDLE.
REQ-027 No overlap: the next accept SHALL occur no earlier than the cycle after the response handshake (minimum 2 cycles per access with WAIT_CYCLES=0).
REQ-028 A load after a store to the same word SHALL return the post-store data.

Reset
REQ-029 On rst: state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 while rst is high and 1 after release.
REQ-030 The array SHALL NOT be reset; its contents SHALL survive rst.
REQ-031 If rst asserts in WAIT, the pending store SHALL NOT be committed; a response already in RESP SHALL be dropped.

Verification
REQ-032 WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 1 cycle after each accept, rdata=0xDEADBEEF, err=0.
REQ-033 Word @0x20=0x11223344; SB 0xAA @0x22; LB @0x22 -> 0xFFFFFFAA; LBU @0x22 -> 0x000000AA; LW @0x20 -> 0x11AA3344.
REQ-034 LH @0x21 -> err=1, rdata=0; SW @0x13 -> err=1 and a later LW @0x10 SHALL show the word unchanged; LW @4*DEPTH -> err=1.
REQ-035 WAIT_CYCLES=3, rsp_ready held low 5 cycles -> rsp_valid asserts 4 cycles after accept, rdata stable throughout, req_ready=0 until the handshake.
REQ-036 WAIT_CYCLES=3: SW 0x5 @0x40, rst pulsed in the second WAIT cycle -> FSM in IDLE, rsp_valid=0, later LW @0x40 returns the prior contents.
